veggie_trajectory: RTL

- Generates per-frame positions for the two veggie halves consumed by game_logic: spawn, parabolic flight, split divergence, landing.
- Sits directly upstream of game_logic. Consumes its frame_done pulse, its split pulse and the lfsr_16 random word.
- Returns top/bottom sprite positions, visibility flags and a one-cycle veggie_gone pulse.

---
 rtl/veggie_pkg.sv | 58 +++++
 rtl/veggie_body_step.sv | 47 ++++
 rtl/veggie_trajectory.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/veggie_pkg.sv
// Shared types and constants for the veggie trajectory generator.
// Positions and velocities use one signed 12-bit type, which keeps the
// integrator free of width juggling.
package veggie_pkg;

    typedef logic signed [11:0] vel_t;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_FLYING = 2'd1,
        ST_SPLIT  = 2'd2
    } state_t;

    typedef struct packed {
        vel_t x;
        vel_t y;
        vel_t vx;
        vel_t vy;
        logic landed;
    } body_t;

    localparam int SCREEN_W       = 1024;
    localparam int SCREEN_H       = 768;
    localparam int VEG_W          = 64;
    localparam int VEG_H          = 64;
    localparam int RESPAWN_FRAMES = 30;

    localparam vel_t GRAVITY     = 12'sd1;
    localparam vel_t LAUNCH_VY   = 12'sd20;
    localparam vel_t MAX_FALL_VY = 12'sd24;
    localparam vel_t SPLIT_DX    = 12'sd2;
    localparam vel_t SPLIT_KICK  = 12'sd3;
    localparam vel_t SPAWN_X_MIN = 12'sd192;

    // Derived geometry: right wall for the sprite's left edge, off-screen
    // parking row, spawn row and the two landing lines.
    localparam vel_t X_MAX         = vel_t'(SCREEN_W - VEG_W);
    localparam vel_t SCREEN_BOTTOM = vel_t'(SCREEN_H);
    localparam vel_t HALF_H        = vel_t'(VEG_H / 2);
    localparam vel_t SPAWN_TOP_Y   = vel_t'(SCREEN_H - VEG_H);
    localparam vel_t TOP_LAND_Y    = vel_t'(SCREEN_H - VEG_H);
    localparam vel_t BOT_LAND_Y    = vel_t'(SCREEN_H - VEG_H / 2);

    // A half that is parked off-screen and not drawn.
    localparam body_t BODY_OFF = '{x: 12'sd0, y: SCREEN_BOTTOM, vx: 12'sd0,
                                   vy: 12'sd0, landed: 1'b1};

    // Horizontal launch speed picked by two random bits; never zero.
    function automatic vel_t spawn_vx(input logic [1:0] sel);
        case (sel)
            2'd0:    return -12'sd2;
            2'd1:    return -12'sd1;
            2'd2:    return 12'sd1;
            default: return 12'sd2;
        endcase
    endfunction

endpackage

// File: rtl/veggie_body_step.sv
// One frame of motion for a single veggie half: position advance with the
// old velocity, gravity with a fall-speed clamp, side-wall bounce, ceiling
// clamp and landing detection against the supplied landing line.
module veggie_body_step
    import veggie_pkg::*;
(
    input  body_t body_i,
    input  vel_t  land_y_i,
    output body_t body_o
);

    vel_t x_sum;
    vel_t y_sum;
    vel_t vy_inc;

    // Integrate one frame; landing overrides the ceiling clamp since a
    // falling half can never be above the top edge.
    always_comb begin
        x_sum  = body_i.x + body_i.vx;
        y_sum  = body_i.y + body_i.vy;
        vy_inc = body_i.vy + GRAVITY;

        body_o    = body_i;
        body_o.x  = x_sum;
        body_o.y  = y_sum;
        body_o.vy = (vy_inc > MAX_FALL_VY) ? MAX_FALL_VY : vy_inc;

        if (x_sum < 12'sd0) begin
            body_o.x  = 12'sd0;
            body_o.vx = -body_i.vx;
        end else if (x_sum > X_MAX) begin
            body_o.x  = X_MAX;
            body_o.vx = -body_i.vx;
        end

        if (y_sum < 12'sd0) begin
            body_o.y  = 12'sd0;
            body_o.vy = GRAVITY;
        end

        if ((body_i.vy > 12'sd0) && (y_sum >= land_y_i)) begin
            body_o.y      = SCREEN_BOTTOM;
            body_o.landed = 1'b1;
        end
    end

endmodule

// File: rtl/veggie_trajectory.sv
// Veggie trajectory generator: waits, spawns a veggie from the random word,
// flies it as one body, and after a katana hit flies the two halves apart
// until both have landed.
// Build option: define VEG_SPEEDUP_EN to make launches faster every 8 spawns.
// Handshake: there is no valid/ready; every motion update is qualified by the
// one-cycle frame_done_in strobe, split_in is honoured on any cycle, and the
// veggie_gone_out / missed_out pulses are registered and last one cycle.
module veggie_trajectory
    import veggie_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_done_in,
    input  logic        split_in,
    input  logic [15:0] random_in,
    output logic [10:0] top_x_out,
    output logic [9:0]  top_y_out,
    output logic [10:0] bottom_x_out,
    output logic [9:0]  bottom_y_out,
    output logic        top_visible_out,
    output logic        bottom_visible_out,
    output logic        split_out,
    output logic        veggie_gone_out,
    output logic        missed_out
);

    state_t     state_q;
    logic [4:0] wait_cnt_q;
    body_t      top_q;
    body_t      bot_q;
    logic       gone_q;
    logic       missed_q;

    body_t top_nx;
    body_t bot_nx;
    body_t bot_miss;
    body_t spawn_top;
    body_t spawn_bot;
    vel_t  launch_vy;
    logic  spawn_fire;
    logic  both_down;

    veggie_body_step u_top_step (
        .body_i   (top_q),
        .land_y_i (TOP_LAND_Y),
        .body_o   (top_nx)
    );

    veggie_body_step u_bot_step (
        .body_i   (bot_q),
        .land_y_i (BOT_LAND_Y),
        .body_o   (bot_nx)
    );

    assign spawn_fire = (state_q == ST_WAIT) && frame_done_in && (wait_cnt_q == 5'd1);
    assign both_down  = top_nx.landed && bot_nx.landed;

`ifdef VEG_SPEEDUP_EN
    logic [5:0] spawn_cnt_q;
    logic [1:0] boost;

    // min(spawn_cnt >> 3, 3): bit 5 set means the shifted count is 4 or more.
    assign boost = spawn_cnt_q[5] ? 2'd3 : spawn_cnt_q[4:3];

    // Saturating count of spawns since reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            spawn_cnt_q <= 6'd0;
        end else if (spawn_fire && (spawn_cnt_q != 6'd63)) begin
            spawn_cnt_q <= spawn_cnt_q + 6'd1;
        end
    end

    assign launch_vy = LAUNCH_VY + vel_t'({10'd0, random_in[12:11]})
                     + vel_t'({10'd0, boost});
`else
    assign launch_vy = LAUNCH_VY + vel_t'({10'd0, random_in[12:11]});
`endif

    // Spawn bodies built from the random word, plus the bottom half forced
    // off-screen when an unsplit veggie is missed.
    always_comb begin
        spawn_top        = BODY_OFF;
        spawn_top.x      = SPAWN_X_MIN + vel_t'({3'd0, random_in[8:0]});
        spawn_top.y      = SPAWN_TOP_Y;
        spawn_top.vx     = spawn_vx(random_in[10:9]);
        spawn_top.vy     = -launch_vy;
        spawn_top.landed = 1'b0;

        spawn_bot   = spawn_top;
        spawn_bot.y = SPAWN_TOP_Y + HALF_H;

        bot_miss        = bot_nx;
        bot_miss.y      = SCREEN_BOTTOM;
        bot_miss.landed = 1'b1;
    end

    // Game-state FSM with the body registers and the one-cycle pulses.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ST_WAIT;
            wait_cnt_q <= 5'(RESPAWN_FRAMES);
            top_q      <= BODY_OFF;
            bot_q      <= BODY_OFF;
            gone_q     <= 1'b0;
            missed_q   <= 1'b0;
        end else begin
            gone_q   <= 1'b0;
            missed_q <= 1'b0;
            case (state_q)
                ST_WAIT: begin
                    if (spawn_fire) begin
                        top_q      <= spawn_top;
                        bot_q      <= spawn_bot;
                        wait_cnt_q <= 5'd0;
                        state_q    <= ST_FLYING;
                    end else if (frame_done_in) begin
                        wait_cnt_q <= wait_cnt_q - 5'd1;
                    end
                end
                ST_FLYING: begin
                    if (split_in) begin
                        top_q.vx <= top_q.vx - SPLIT_DX;
                        top_q.vy <= top_q.vy - SPLIT_KICK;
                        bot_q.vx <= bot_q.vx + SPLIT_DX;
                        state_q  <= ST_SPLIT;
                    end else if (frame_done_in) begin
                        top_q <= top_nx;
                        if (top_nx.landed) begin
                            bot_q      <= bot_miss;
                            missed_q   <= 1'b1;
                            gone_q     <= 1'b1;
                            wait_cnt_q <= 5'(RESPAWN_FRAMES);
                            state_q    <= ST_WAIT;
                        end else begin
                            bot_q <= bot_nx;
                        end
                    end
                end
                ST_SPLIT: begin
                    if (frame_done_in) begin
                        if (!top_q.landed) top_q <= top_nx;
                        if (!bot_q.landed) bot_q <= bot_nx;
                        if (both_down) begin
                            gone_q     <= 1'b1;
                            wait_cnt_q <= 5'(RESPAWN_FRAMES);
                            state_q    <= ST_WAIT;
                        end
                    end
                end
                default: begin
                    state_q <= ST_WAIT;
                end
            endcase
        end
    end

    assign top_x_out          = top_q.x[10:0];
    assign top_y_out          = top_q.y[9:0];
    assign bottom_x_out       = bot_q.x[10:0];
    assign bottom_y_out       = bot_q.y[9:0];
    assign top_visible_out    = ~top_q.landed;
    assign bottom_visible_out = ~bot_q.landed;
    assign split_out          = (state_q == ST_SPLIT);
    assign veggie_gone_out    = gone_q;
    assign missed_out         = missed_q;

    // High position bits stay inside the screen range and the top random bits
    // are reserved for other consumers of the LFSR word.
    logic unused_bits;
    assign unused_bits = ^{top_q.x[11], top_q.y[11:10], bot_q.x[11],
                           bot_q.y[11:10], random_in[15:13]};

endmodule
